// File: rtl/keysched_state_gate.sv
// keysched_state_gate
//   Time-multiplexed key gate that owns a host FSM's present-state register.
//   A free-running counter splits time into NUM_KEYS windows of WINDOW edges;
//   each window has its own key. On every falling edge a matching key_in
//   lets nx_state through, a mismatch corrupts the state according to MODE
//   (0 per-edge decoy, 1 sticky decoy, 2 XOR perturbation; others act as 0).
// Ports
//   clk      : clock, all registers update on the falling edge
//   rst      : asynchronous active-high reset
//   key_in   : key bits sampled at each falling edge
//   nx_state : next state from host combinational logic
//   pr_state : present state register, fed back to host
//   win_idx  : registered window index of the post-update counter
module keysched_state_gate #(
    parameter int unsigned STATE_W = 5,
    parameter int unsigned KEY_W = 9,
    parameter int unsigned NUM_KEYS = 3,
    parameter int unsigned WINDOW = 9,
    parameter logic [NUM_KEYS*KEY_W-1:0] KEYS = {9'd214, 9'd461, 9'd382},
    parameter logic [NUM_KEYS*STATE_W-1:0] DECOYS = {5'd5, 5'd14, 5'd6},
    parameter logic [STATE_W-1:0] RESET_STATE = STATE_W'(1),
    parameter int unsigned MODE = 0,
    localparam int unsigned WIN_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   key_in,
    input  logic [STATE_W-1:0] nx_state,
    output logic [STATE_W-1:0] pr_state,
    output logic [WIN_W-1:0]   win_idx
);

    localparam int unsigned PERIOD = NUM_KEYS * WINDOW;
    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [WIN_W-1:0]   win_cur;
    logic [WIN_W-1:0]   win_next;
    logic [KEY_W-1:0]   key_cur;
    logic [STATE_W-1:0] decoy_cur;
    logic [KEY_W-1:0]   diff;
    logic [STATE_W-1:0] fold;
    logic               match;
    logic               sticky;
    logic               sticky_next;
    logic [STATE_W-1:0] state_next;

    // Window is always derived from the pre-increment counter of this edge.
    assign cnt_next  = (cnt == CNT_W'(PERIOD - 1)) ? '0 : cnt + CNT_W'(1);
    assign win_cur   = WIN_W'(32'(cnt) / WINDOW);
    assign win_next  = WIN_W'(32'(cnt_next) / WINDOW);
    assign key_cur   = KEYS[win_cur*KEY_W +: KEY_W];
    assign decoy_cur = DECOYS[win_cur*STATE_W +: STATE_W];
    assign diff      = key_in ^ key_cur;
    assign match     = (diff == '0);

    // XOR-fold of the key difference into STATE_W-bit chunks; bit i of the
    // difference lands on bit (i mod STATE_W), which zero-pads the top chunk.
    always_comb begin
        fold = '0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            fold[i % STATE_W] = fold[i % STATE_W] ^ diff[i];
        end
    end

    always_comb begin
        state_next  = nx_state;
        sticky_next = sticky;
        if (MODE == 1) begin
            if (sticky || !match) begin
                state_next  = decoy_cur;
                sticky_next = 1'b1;
            end
        end else if (MODE == 2) begin
            state_next = nx_state ^ fold;
        end else if (!match) begin
            state_next = decoy_cur;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            win_idx  <= '0;
            sticky   <= 1'b0;
            pr_state <= RESET_STATE;
        end else begin
            cnt      <= cnt_next;
            win_idx  <= win_next;
            sticky   <= sticky_next;
            pr_state <= state_next;
        end
    end

endmodule

// File: tb/tb_keysched_state_gate.sv
// tb_keysched_state_gate
//   Directed bench for keysched_state_gate with default parameters, one
//   instance per MODE (0, 1, 2) sharing clock, reset and stimulus.
module tb_keysched_state_gate;

    logic       clk;
    logic       rst;
    logic [8:0] key;
    logic [4:0] nx;
    logic [4:0] pr0, pr1, pr2;
    logic [1:0] wi0, wi1, wi2;

    int vectors = 0;
    int miscompares = 0;

    keysched_state_gate #(.MODE(0)) dut0 (
        .clk(clk), .rst(rst), .key_in(key), .nx_state(nx), .pr_state(pr0), .win_idx(wi0)
    );
    keysched_state_gate #(.MODE(1)) dut1 (
        .clk(clk), .rst(rst), .key_in(key), .nx_state(nx), .pr_state(pr1), .win_idx(wi1)
    );
    keysched_state_gate #(.MODE(2)) dut2 (
        .clk(clk), .rst(rst), .key_in(key), .nx_state(nx), .pr_state(pr2), .win_idx(wi2)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a falling edge, far from the next one.
    task automatic step(input logic [8:0] k, input logic [4:0] n);
        key = k;
        nx  = n;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [8:0] goodkey(input int c);
        int w;
        w = (c % 27) / 9;
        if (w == 0) return 9'd382;
        if (w == 1) return 9'd461;
        return 9'd214;
    endfunction

    function automatic logic [4:0] decoy_of(input int c);
        int w;
        w = (c % 27) / 9;
        if (w == 0) return 5'd6;
        if (w == 1) return 5'd14;
        return 5'd5;
    endfunction

    initial begin
        rst = 1'b1;
        key = '0;
        nx  = '0;
        #3;
        check("reset_pr0", pr0, 1);
        check("reset_pr1", pr1, 1);
        check("reset_pr2", pr2, 1);
        check("reset_win", wi0, 0);
        check("reset_cnt", dut0.cnt, 0);
        rst = 1'b0;

        // Correct schedule over 60 edges, counter wraps 26 -> 0.
        for (int c = 0; c < 60; c++) begin
            step(goodkey(c), 5'd7);
            check("sched_pr0", pr0, 7);
            check("sched_pr1", pr1, 7);
            check("sched_pr2", pr2, 7);
            check("sched_win", wi0, ((c + 1) % 27) / 9);
            check("sched_cnt", dut0.cnt, (c + 1) % 27);
        end

        // Zero key during window 1 only.
        do_reset();
        for (int c = 0; c < 27; c++) begin
            step((c >= 9 && c <= 17) ? 9'd0 : goodkey(c), 5'd7);
            check("w1bad_m0", pr0, (c >= 9 && c <= 17) ? 14 : 7);
            check("w1bad_m1", pr1, (c < 9) ? 7 : decoy_of(c));
            check("w1bad_m2", pr2, (c >= 9 && c <= 17) ? 4 : 7);
        end

        // Single wrong key at c4: sticky from then on.
        do_reset();
        for (int c = 0; c < 30; c++) begin
            step((c == 4) ? 9'd0 : goodkey(c), 5'd7);
            check("c4bad_m0", pr0, (c == 4) ? 6 : 7);
            check("c4bad_m1", pr1, (c < 4) ? 7 : decoy_of(c));
            check("c4bad_m2", pr2, (c == 4) ? 18 : 7);
        end

        // XOR perturbation, including a fold from the second chunk.
        do_reset();
        step(9'd382, 5'd8);
        step(9'd382, 5'd8);
        check("xor_ok", pr2, 8);
        step(9'd382 ^ 9'd3, 5'd8);
        check("xor_low", pr2, 11);
        check("xor_m0", pr0, 6);
        step(9'd382 ^ 9'd32, 5'd8);
        check("xor_fold", pr2, 9);

        // Async reset mid-phase at c=13 clears sticky flag.
        do_reset();
        step(9'd0, 5'd7);
        check("pre_sticky", dut1.sticky, 1);
        for (int c = 1; c < 13; c++) step(goodkey(c), 5'd7);
        check("pre_cnt", dut0.cnt, 13);
        #2;
        rst = 1'b1;
        #1;
        check("async_pr0", pr0, 1);
        check("async_pr1", pr1, 1);
        check("async_win", wi0, 0);
        check("async_cnt", dut0.cnt, 0);
        check("async_sticky", dut1.sticky, 0);
        #1;
        rst = 1'b0;
        step(9'd382, 5'd7);
        check("post_rst_m1", pr1, 7);

        // Key switch at the window boundary, then one edge early.
        do_reset();
        for (int c = 0; c < 9; c++) step(9'd382, 5'd7);
        check("switch_c8", pr0, 7);
        step(9'd461, 5'd7);
        check("switch_c9", pr0, 7);
        check("switch_win", wi0, 1);
        do_reset();
        for (int c = 0; c < 8; c++) step(9'd382, 5'd7);
        step(9'd461, 5'd7);
        check("early_c8", pr0, 6);
        step(9'd461, 5'd7);
        check("early_c9", pr0, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
